alu_exec_unit: RTL and testbench
================================

Name: alu_exec_unit

Overview:
- Execute-stage consumer of the 4-bit ALUControl code produced by the ALU decoder.
- Accepts an operation plus two operands over a valid/ready handshake. Computes the result and returns it over a second valid/ready handshake.
- Logic ops, add/sub and compares complete in one cycle. Shifts run iteratively, one bit per cycle, so the block is usable by the multi-cycle datapath.

Parameters:
- XLEN, 32, operand/result width; must be 32 or 64.
- SHAMT_W, 5, shift-amount width taken from b[SHAMT_W-1:0]; 6 when XLEN=64.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- in_valid  input  1  operation request valid
- in_ready  output  1  block can accept a request
- alu_control  input  4  operation code (encoding in Decomposition)
- a  input  XLEN  operand A
- b  input  XLEN  operand B / shift amount
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- result  output  XLEN  registered result
- zero  output  1  result == 0, registered with result
- illegal_op  output  1  alu_control was an unassigned code

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-high.
- Reset values: state=IDLE, out_valid=0, result=0, zero=0, illegal_op=0, shift counter=0.
- Reset asserted mid-operation aborts the operation. No result is delivered.
- FSM states: IDLE, SHIFT, DONE.
- in_ready = (state==IDLE), combinational from state only.
- Accept: in_valid && in_ready at a rising edge latches alu_control, a and b.
- Non-shift op accepted: result, zero and illegal_op are written at that edge; next state is DONE; out_valid rises the following cycle (latency 1).
- Shift op accepted with shamt = b[SHAMT_W-1:0]:
  - shamt==0: result=a, next state DONE (latency 1).
  - shamt>0: working register=a, counter=shamt, next state SHIFT.
- SHIFT state: each cycle, working register shifts 1 bit (SLL: left, zero fill; SRL: right, zero fill; SRA: right, sign fill) and counter decrements. When counter reaches 1, the last shift is written to result and the state moves to DONE. Total latency = shamt cycles from the accepting edge to out_valid.
- DONE state: out_valid=1. result, zero and illegal_op stay stable until out_valid && out_ready, then the state returns to IDLE and out_valid drops.
- No new request is accepted in the same cycle a result is consumed. Throughput is at most one op per 2 cycles.
- Arithmetic:
  - ADD/SUB wrap modulo 2^XLEN, with no carry or overflow output.
  - SLT is a signed compare; SLTU is unsigned. Both produce a result of 0 or 1, zero-extended.
- Unassigned alu_control codes: result=0, zero=1, illegal_op=1, latency 1.
- Inputs are ignored while in_ready=0. in_valid may drop without penalty before acceptance.
- out_ready held high in DONE consumes the result on the first DONE cycle.

Optional Feature:
- Macro: ALU_EXEC_FAST_SHIFT_EN.
- Defined: shifts use a single-cycle barrel shifter, SHIFT state is never entered, and every op has latency 1.
- Undefined: iterative shifting as described above.
- Handshake, reset values and result values are identical in both builds. Only latency differs.

Decomposition:
- Package alu_pkg holds the ALUControl localparams: ADD=0000, SUB=0001, AND=0010, OR=0011, XOR=0100, SLT=0101, SLTU=0110, SLL=0111, SRL=1000, SRA=1001; codes 1010-1111 are unassigned.
- alu_pkg also holds the FSM state encoding. The ALU decoder must be updated to import alu_pkg.
- One sub-module, alu_serial_shifter: holds the working register and counter, has start/done ports, and is replaced by combinational shift logic under ALU_EXEC_FAST_SHIFT_EN.

Test Plan:
- Reset during SHIFT: start SLL with a=1, b=31, assert reset at cycle 10 -> out_valid=0, in_ready=1 after release, result=0.
- ADD: a=0x7FFFFFFF, b=1, out_ready=1 -> out_valid one cycle after accept, result=0x80000000, zero=0. SUB with a=5, b=5 -> result=0, zero=1.
- SLT vs SLTU: a=0xFFFFFFFF, b=1 -> SLT result=1, SLTU result=0.
- SRA: a=0x80000000, b=4 -> out_valid exactly 4 cycles after accept, result=0xF8000000; in_ready=0 throughout. With the macro defined, latency=1 and the result is the same.
- Backpressure: OR with a=0xF0, b=0x0F, out_ready=0 for 5 cycles -> result=0xFF held stable, a second in_valid is not accepted; accepted the cycle after out_ready=1.
- Illegal code: alu_control=1111 -> result=0, zero=1, illegal_op=1. SLL with b=0x20 (shamt=0) -> result=a, latency 1.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: ALUControl encoding, exec-unit FSM states and op helpers.
// Shared by the ALU decoder and alu_exec_unit.
package alu_pkg;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLT  = 4'b0101;
  localparam logic [3:0] ALU_SLTU = 4'b0110;
  localparam logic [3:0] ALU_SLL  = 4'b0111;
  localparam logic [3:0] ALU_SRL  = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1001;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  function automatic logic is_shift_op(input logic [3:0] code);
    return (code == ALU_SLL) ||
           (code == ALU_SRL) ||
           (code == ALU_SRA);
  endfunction

endpackage

// File: rtl/alu_serial_shifter.sv
// alu_serial_shifter: one-bit-per-cycle shifter with start/done.
// done is asserted in the cycle whose shift is the final one.
module alu_serial_shifter
  import alu_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [3:0]         op,
  input  logic [XLEN-1:0]    din,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               done,
  output logic [XLEN-1:0]    dout
);

  logic [XLEN-1:0]    work;
  logic [XLEN-1:0]    step;
  logic [SHAMT_W-1:0] cnt;
  logic [3:0]         op_q;

  always_comb begin
    step = {1'b0, work[XLEN-1:1]};
    unique case (1'b1)
      (op_q == ALU_SLL):
        step = {work[XLEN-2:0], 1'b0};
      (op_q == ALU_SRA):
        step = {work[XLEN-1], work[XLEN-1:1]};
      default:
        step = {1'b0, work[XLEN-1:1]};
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      work <= '0;
      cnt  <= '0;
      op_q <= ALU_SLL;
    end else if (start) begin
      work <= din;
      cnt  <= shamt;
      op_q <= op;
    end else if (cnt != '0) begin
      work <= step;
      cnt  <= cnt - 1'b1;
    end
  end

  assign done = (cnt == SHAMT_W'(1));
  assign dout = step;

endmodule

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: execute-stage ALU with valid/ready in and out.
// Define ALU_EXEC_FAST_SHIFT_EN for single-cycle barrel shifts.
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int SHAMT_W = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      alu_control,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            illegal_op
);

  state_t state;
  state_t state_nx;

  logic               accept;
  logic               go_serial;
  logic               sh_done;
  logic [XLEN-1:0]    sh_dout;
  logic [XLEN-1:0]    shift_res;
  logic [XLEN-1:0]    alu_res;
  logic               alu_ill;
  logic [SHAMT_W-1:0] shamt;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;
  assign shamt     = b[SHAMT_W-1:0];

`ifdef ALU_EXEC_FAST_SHIFT_EN
  always_comb begin
    shift_res = a;
    unique case (1'b1)
      (alu_control == ALU_SLL):
        shift_res = a << shamt;
      (alu_control == ALU_SRL):
        shift_res = a >> shamt;
      default:
        shift_res = $signed(a) >>> shamt;
    endcase
  end

  assign go_serial = 1'b0;
  assign sh_done   = 1'b0;
  assign sh_dout   = '0;
`else
  // Only the shamt==0 case completes here; others go serial.
  assign shift_res = a;
  assign go_serial = accept &&
                     is_shift_op(alu_control) &&
                     (shamt != '0);

  alu_serial_shifter #(
    .XLEN    (XLEN),
    .SHAMT_W (SHAMT_W)
  ) u_shifter (
    .clk   (clk),
    .reset (reset),
    .start (go_serial),
    .op    (alu_control),
    .din   (a),
    .shamt (shamt),
    .done  (sh_done),
    .dout  (sh_dout)
  );
`endif

  always_comb begin
    alu_res = '0;
    alu_ill = 1'b0;
    unique case (alu_control)
      ALU_ADD:  alu_res = a + b;
      ALU_SUB:  alu_res = a - b;
      ALU_AND:  alu_res = a & b;
      ALU_OR:   alu_res = a | b;
      ALU_XOR:  alu_res = a ^ b;
      ALU_SLT:
        alu_res = {{(XLEN-1){1'b0}},
                   $signed(a) < $signed(b)};
      ALU_SLTU:
        alu_res = {{(XLEN-1){1'b0}}, a < b};
      ALU_SLL,
      ALU_SRL,
      ALU_SRA:  alu_res = shift_res;
      default:  alu_ill = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:
        if (accept)
          state_nx = go_serial ? SHIFT : DONE;
      SHIFT:
        if (sh_done) state_nx = DONE;
      DONE:
        if (out_ready) state_nx = IDLE;
      default:
        state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      result     <= '0;
      zero       <= 1'b0;
      illegal_op <= 1'b0;
    end else if (accept && !go_serial) begin
      result     <= alu_res;
      zero       <= (alu_res == '0);
      illegal_op <= alu_ill;
    end else if ((state == SHIFT) && sh_done) begin
      result     <= sh_dout;
      zero       <= (sh_dout == '0);
      illegal_op <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: directed + random ops against a reference model.
// Latency is counted in clock edges from accept to out_valid rising.
module tb_alu_exec_unit;

`ifdef ALU_EXEC_FAST_SHIFT_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  alu_control;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;
  logic        illegal_op;

  int vectors    = 0;
  int miscompares = 0;

  alu_exec_unit #(.XLEN(32), .SHAMT_W(5)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .alu_control (alu_control),
    .a           (a),
    .b           (b),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .result      (result),
    .zero        (zero),
    .illegal_op  (illegal_op)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  // {illegal, result}
  function automatic logic [32:0] ref_alu(
    input logic [3:0] c,
    input logic [31:0] x,
    input logic [31:0] y);
    int s;
    int sx;
    int sy;
    logic [31:0] r;
    logic        ill;
    s   = int'(y % 32);
    sx  = x;
    sy  = y;
    r   = 32'd0;
    ill = 1'b0;
    case (c)
      4'd0: r = x + y;
      4'd1: r = x - y;
      4'd2: r = x & y;
      4'd3: r = x | y;
      4'd4: r = x ^ y;
      4'd5: r = (sx < sy) ? 32'd1 : 32'd0;
      4'd6: r = (x < y) ? 32'd1 : 32'd0;
      4'd7: r = x << s;
      4'd8: r = x >> s;
      4'd9: begin
        r = x >> s;
        if (x[31]) r = r | ~(32'hFFFF_FFFF >> s);
      end
      default: ill = 1'b1;
    endcase
    return {ill, r};
  endfunction

  task automatic run_op(input logic [3:0] c,
                        input logic [31:0] x,
                        input logic [31:0] y,
                        input int hold);
    logic [32:0] m;
    logic [31:0] held;
    int n;
    int exp_lat;
    m = ref_alu(c, x, y);
    exp_lat = 0;
    if (!FAST && (c inside {4'd7, 4'd8, 4'd9}))
      exp_lat = int'(y % 32);
    @(negedge clk);
    n = 0;
    while (!in_ready && n < 80) begin
      @(negedge clk);
      n++;
    end
    chk("idle_ready", in_ready, 1);
    in_valid    = 1'b1;
    alu_control = c;
    a           = x;
    b           = y;
    out_ready   = 1'b0;
    @(posedge clk);
    #1;
    in_valid    = 1'b0;
    alu_control = 4'($urandom);
    a           = $urandom;
    b           = $urandom;
    n = 0;
    while (!out_valid && n < 80) begin
      chk("busy_ready", in_ready, 0);
      @(posedge clk);
      #1;
      n++;
    end
    chk("latency", n, exp_lat);
    chk("result", result, m[31:0]);
    chk("zero", zero, (m[31:0] == 32'd0));
    chk("illegal", illegal_op, m[32]);
    held = result;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      chk("hold_valid", out_valid, 1);
      chk("hold_result", result, held);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("consumed", out_valid, 0);
    chk("ready_again", in_ready, 1);
  endtask

  initial begin
    logic [3:0]  c;
    logic [31:0] x;
    logic [31:0] y;

    reset       = 1'b1;
    in_valid    = 1'b0;
    alu_control = 4'd0;
    a           = 32'd0;
    b           = 32'd0;
    out_ready   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_result", result, 0);
    chk("rst_zero", zero, 0);
    chk("rst_illegal", illegal_op, 0);
    @(negedge clk);
    reset = 1'b0;

    // Reset in the middle of a long shift.
    @(negedge clk);
    in_valid    = 1'b1;
    alu_control = 4'b0111;
    a           = 32'd1;
    b           = 32'd31;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    chk("abort_valid", out_valid, 0);
    chk("abort_ready", in_ready, 1);
    chk("abort_result", result, 0);
    chk("abort_zero", zero, 0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_idle", out_valid, 0);

    run_op(4'd0, 32'h7FFF_FFFF, 32'd1, 0);
    run_op(4'd1, 32'd5, 32'd5, 0);
    run_op(4'd5, 32'hFFFF_FFFF, 32'd1, 0);
    run_op(4'd6, 32'hFFFF_FFFF, 32'd1, 0);
    run_op(4'd9, 32'h8000_0000, 32'd4, 1);
    run_op(4'd15, 32'h1234_5678, 32'h9, 0);
    run_op(4'd7, 32'hDEAD_BEEF, 32'h20, 0);
    run_op(4'd8, 32'h8000_0001, 32'd1, 0);
    run_op(4'd7, 32'd1, 32'd31, 0);
    run_op(4'd10, 32'd0, 32'd0, 0);

    // Backpressure with a second request waiting.
    @(negedge clk);
    in_valid    = 1'b1;
    alu_control = 4'd3;
    a           = 32'h0000_00F0;
    b           = 32'h0000_000F;
    out_ready   = 1'b0;
    @(posedge clk);
    #1;
    alu_control = 4'd0;
    a           = 32'd1;
    b           = 32'd2;
    chk("bp_valid", out_valid, 1);
    chk("bp_result", result, 32'hFF);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("bp_hold_valid", out_valid, 1);
      chk("bp_hold_result", result, 32'hFF);
      chk("bp_not_ready", in_ready, 0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("bp_consumed", out_valid, 0);
    chk("bp_ready", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("bp_second_valid", out_valid, 1);
    chk("bp_second_result", result, 32'd3);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("bp_second_done", out_valid, 0);

    for (int k = 0; k < 40; k++) begin
      c = 4'($urandom_range(0, 15));
      x = $urandom;
      if ($urandom_range(0, 2) == 0)
        x = 32'($urandom_range(0, 3)) << 30;
      y = $urandom;
      if ($urandom_range(0, 3) == 0)
        y = 32'($urandom_range(0, 40));
      run_op(c, x, y, $urandom_range(0, 2));
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
